mem_stage: RTL and testbench

//  Memory stage of the WISC-SP20 pipeline, directly downstream of execute. Takes the execute

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_stage_dff.sv | 15 +
 rtl/mem_stage_dmem_ctrl.sv | 69 ++++++
 rtl/mem_stage.sv | 104 ++++++++++
 tb/tb_mem_stage.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encodings, default widths and the access-error check
package mem_stage_pkg;

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    localparam int DATA_W_DEF  = 16;
    localparam int REG_W_DEF   = 3;
    localparam int TIMEOUT_DEF = 64;

    // A word access must be even-aligned and cannot be both a load and a store
    function automatic logic mem_bad(input logic a0, input logic rd, input logic wr);
        return a0 | (rd & wr);
    endfunction

endpackage

// File: rtl/mem_stage_dff.sv
// dff: synchronous active-high reset register, the only flop primitive in this stage
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // clear on reset, otherwise load d every cycle (hold is done by the caller's mux)
    always_ff @(posedge clk)
        q <= rst ? '0 : d;

endmodule

// File: rtl/mem_stage_dmem_ctrl.sv
// dmem_ctrl: IDLE/BUSY handshake FSM with wait counter and registered dmem request
module dmem_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic              i_done,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_rd,
    output logic              o_wr,
    output logic              o_done_evt,
    output logic              o_timeout_evt,
    output logic [DATA_W-1:0] o_rdata_q
);

    // The counter only has to reach TIMEOUT-1: the cycle it sits there is the last BUSY cycle
    localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic            TO_EN = (TIMEOUT > 0);

    logic              r_state, w_state_d;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;
    logic [DATA_W-1:0] r_addr, w_addr_d;
    logic [DATA_W-1:0] r_wdata, w_wdata_d;
    logic              r_rd, w_rd_d;
    logic              r_wr, w_wr_d;
    logic              w_busy, w_end;

    assign w_busy        = (r_state == BUSY);
    assign o_done_evt    = w_busy & i_done;
    assign o_timeout_evt = TO_EN & w_busy & ~i_done & (r_cnt == LAST);
    assign w_end         = o_done_evt | o_timeout_evt;

    // next state: start enters BUSY, done (which beats timeout) or timeout returns to IDLE
    always_comb begin
        w_state_d = i_start ? BUSY : w_end ? IDLE : r_state;
        w_cnt_d   = (w_busy & ~w_end) ? r_cnt + CNT_W'(1) : '0;
        w_addr_d  = i_start ? i_addr : r_addr;
        w_wdata_d = i_start ? i_wdata : r_wdata;
        w_rd_d    = i_start ? i_rd : (r_rd & ~w_end);
        w_wr_d    = i_start ? i_wr : (r_wr & ~w_end);
    end

    dff #(.W(1))      u_state (.clk(clk), .rst(rst), .d(w_state_d), .q(r_state));
    dff #(.W(CNT_W))  u_cnt   (.clk(clk), .rst(rst), .d(w_cnt_d),   .q(r_cnt));
    dff #(.W(DATA_W)) u_addr  (.clk(clk), .rst(rst), .d(w_addr_d),  .q(r_addr));
    dff #(.W(DATA_W)) u_wdata (.clk(clk), .rst(rst), .d(w_wdata_d), .q(r_wdata));
    dff #(.W(1))      u_rd    (.clk(clk), .rst(rst), .d(w_rd_d),    .q(r_rd));
    dff #(.W(1))      u_wr    (.clk(clk), .rst(rst), .d(w_wr_d),    .q(r_wr));

    assign o_busy    = w_busy;
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;
    assign o_rd      = r_rd;
    assign o_wr      = r_wr;
    assign o_rdata_q = (o_done_evt & r_rd) ? i_rdata : '0;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: WISC-SP20 memory stage - accept, alignment check, dmem handshake and MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic [REG_W-1:0]  ex_wr_reg,
    input  logic              ex_halt,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_rd,
    output logic              dmem_wr,
    output logic              dmem_createdump,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_done,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_wr_reg,
    output logic              wb_halt,
    output logic              wb_err
);

    localparam int WB_W = DATA_W + REG_W + 5;

    logic              w_busy, w_done_evt, w_timeout_evt;
    logic [DATA_W-1:0] w_rdata_q;
    logic              w_acc, w_mem, w_bad, w_start, w_direct, w_ok;
    logic [REG_W-1:0]  r_p_reg, w_p_reg_d;
    logic              r_p_rw, w_p_rw_d;
    logic [DATA_W-1:0] w_wb_data_d;
    logic [REG_W-1:0]  w_wb_reg_d;
    logic              w_wb_valid_d, w_wb_rw_d, w_wb_halt_d, w_wb_err_d;
    logic [WB_W-1:0]   w_wb_q;

    // HALT never touches memory, so any mem flags on it are ignored
    assign ex_ready = ~w_busy;
    assign w_acc    = ex_valid & ex_ready;
    assign w_mem    = (ex_mem_read | ex_mem_write) & ~ex_halt;
    assign w_bad    = w_mem & mem_bad(ex_alu_result[0], ex_mem_read, ex_mem_write);
    assign w_start  = w_acc & w_mem & ~w_bad;
    assign w_direct = w_acc & ~w_start;
    assign w_ok     = w_direct & ~w_bad;

    dmem_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_start),
        .i_addr       (ex_alu_result),
        .i_wdata      (ex_store_data),
        .i_rd         (ex_mem_read),
        .i_wr         (ex_mem_write),
        .i_done       (dmem_done),
        .i_rdata      (dmem_rdata),
        .o_busy       (w_busy),
        .o_addr       (dmem_addr),
        .o_wdata      (dmem_wdata),
        .o_rd         (dmem_rd),
        .o_wr         (dmem_wr),
        .o_done_evt   (w_done_evt),
        .o_timeout_evt(w_timeout_evt),
        .o_rdata_q    (w_rdata_q)
    );

    // write-back fields of an in-flight access, needed again when it completes
    always_comb begin
        w_p_reg_d = w_start ? ex_wr_reg : r_p_reg;
        w_p_rw_d  = w_start ? (ex_reg_write & ex_mem_read) : r_p_rw;
    end

    dff #(.W(REG_W)) u_p_reg (.clk(clk), .rst(rst), .d(w_p_reg_d), .q(r_p_reg));
    dff #(.W(1))     u_p_rw  (.clk(clk), .rst(rst), .d(w_p_rw_d),  .q(r_p_rw));

    // MEM/WB next value: direct retire from IDLE, or completion/timeout of the access
    always_comb begin
        w_wb_valid_d = w_direct | w_done_evt | w_timeout_evt;
        w_wb_err_d   = (w_direct & w_bad) | w_timeout_evt;
        w_wb_data_d  = w_done_evt ? w_rdata_q : w_ok ? ex_alu_result : '0;
        w_wb_rw_d    = w_done_evt ? r_p_rw : (w_ok & ex_reg_write);
        w_wb_reg_d   = (w_done_evt | w_timeout_evt) ? r_p_reg : w_direct ? ex_wr_reg : '0;
        w_wb_halt_d  = w_direct & ex_halt;
    end

    dff #(.W(WB_W)) u_wb (
        .clk(clk),
        .rst(rst),
        .d  ({w_wb_valid_d, w_wb_data_d, w_wb_rw_d, w_wb_reg_d, w_wb_halt_d, w_wb_err_d, w_wb_halt_d}),
        .q  (w_wb_q)
    );

    assign {wb_valid, wb_data, wb_reg_write, wb_wr_reg, wb_halt, wb_err, dmem_createdump} = w_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage (TIMEOUT=4)
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [15:0] ex_alu_result, ex_store_data;
    logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_halt;
    logic [2:0]  ex_wr_reg;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_rd, dmem_wr, dmem_createdump, dmem_done;
    logic        wb_valid, wb_reg_write, wb_halt, wb_err;
    logic [15:0] wb_data;
    logic [2:0]  wb_wr_reg;
    int          n_chk = 0;
    int          n_fail = 0;

    mem_stage #(.DATA_W(16), .REG_W(3), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_wr_reg(ex_wr_reg), .ex_halt(ex_halt),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .dmem_createdump(dmem_createdump), .dmem_rdata(dmem_rdata), .dmem_done(dmem_done),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg_write(wb_reg_write),
        .wb_wr_reg(wb_wr_reg), .wb_halt(wb_halt), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ex();
        ex_valid = 0; ex_alu_result = 0; ex_store_data = 0; ex_mem_read = 0;
        ex_mem_write = 0; ex_reg_write = 0; ex_wr_reg = 0; ex_halt = 0;
    endtask

    task automatic test_reset();
        rst = 1; clr_ex(); dmem_done = 0; dmem_rdata = 0;
        tick(); tick();
        rst = 0;
        n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ex_ready); end
        n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        n_chk++; if ({dmem_rd, dmem_wr, dmem_createdump} !== 3'b000) begin n_fail++; $display("FAIL reset_dmem_ctl got %b want 000", {dmem_rd, dmem_wr, dmem_createdump}); end
        n_chk++; if ({dmem_addr, dmem_wdata, wb_data} !== 48'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", {dmem_addr, dmem_wdata, wb_data}); end
    endtask

    task automatic test_nonmem();
        ex_valid = 1; ex_alu_result = 16'h1234; ex_reg_write = 1; ex_wr_reg = 3;
        n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL nonmem_ready_pre got %b want 1", ex_ready); end
        tick(); clr_ex();
        n_chk++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL nonmem_valid got %b want 1", wb_valid); end
        n_chk++; if (wb_data !== 16'h1234) begin n_fail++; $display("FAIL nonmem_data got %h want 1234", wb_data); end
        n_chk++; if ({wb_wr_reg, wb_reg_write, wb_err, wb_halt} !== 6'b011_1_0_0) begin n_fail++; $display("FAIL nonmem_fields got %b want 011100", {wb_wr_reg, wb_reg_write, wb_err, wb_halt}); end
        n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL nonmem_ready got %b want 1", ex_ready); end
        n_chk++; if (dmem_rd !== 1'b0) begin n_fail++; $display("FAIL nonmem_no_req got %b want 0", dmem_rd); end
        tick();
        n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL nonmem_pulse got %b want 0", wb_valid); end
    endtask

    task automatic test_load();
        ex_valid = 1; ex_mem_read = 1; ex_alu_result = 16'h0040; ex_reg_write = 1; ex_wr_reg = 5;
        tick(); clr_ex();
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (dmem_rd !== 1'b1) begin n_fail++; $display("FAIL load_rd[%0d] got %b want 1", i, dmem_rd); end
            n_chk++; if (dmem_addr !== 16'h0040) begin n_fail++; $display("FAIL load_addr[%0d] got %h want 0040", i, dmem_addr); end
            n_chk++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready[%0d] got %b want 0", i, ex_ready); end
            n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL load_early_wb[%0d] got %b want 0", i, wb_valid); end
            if (i == 2) begin dmem_done = 1; dmem_rdata = 16'hBEEF; end
            tick();
        end
        dmem_done = 0; dmem_rdata = 0;
        n_chk++; if (dmem_rd !== 1'b0) begin n_fail++; $display("FAIL load_rd_drop got %b want 0", dmem_rd); end
        n_chk++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid got %b want 1", wb_valid); end
        n_chk++; if (wb_data !== 16'hBEEF) begin n_fail++; $display("FAIL load_data got %h want beef", wb_data); end
        n_chk++; if ({wb_wr_reg, wb_reg_write, wb_err} !== 5'b101_1_0) begin n_fail++; $display("FAIL load_fields got %b want 10110", {wb_wr_reg, wb_reg_write, wb_err}); end
        n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_after got %b want 1", ex_ready); end
    endtask

    task automatic test_store();
        ex_valid = 1; ex_mem_write = 1; ex_alu_result = 16'h0010; ex_store_data = 16'h00FF;
        ex_reg_write = 1; ex_wr_reg = 2;
        tick(); clr_ex();
        n_chk++; if ({dmem_wr, dmem_rd} !== 2'b10) begin n_fail++; $display("FAIL store_req got %b want 10", {dmem_wr, dmem_rd}); end
        n_chk++; if ({dmem_addr, dmem_wdata} !== 32'h0010_00FF) begin n_fail++; $display("FAIL store_addr_data got %h want 001000ff", {dmem_addr, dmem_wdata}); end
        dmem_done = 1;
        tick(); dmem_done = 0;
        n_chk++; if (dmem_wr !== 1'b0) begin n_fail++; $display("FAIL store_wr_drop got %b want 0", dmem_wr); end
        n_chk++; if ({wb_valid, wb_reg_write, wb_err} !== 3'b100) begin n_fail++; $display("FAIL store_wb got %b want 100", {wb_valid, wb_reg_write, wb_err}); end
        n_chk++; if (wb_data !== 16'h0) begin n_fail++; $display("FAIL store_data got %h want 0000", wb_data); end
    endtask

    task automatic test_errors();
        ex_valid = 1; ex_mem_read = 1; ex_alu_result = 16'h0043; ex_reg_write = 1; ex_wr_reg = 4;
        tick(); clr_ex();
        n_chk++; if (dmem_rd !== 1'b0) begin n_fail++; $display("FAIL misal_no_req got %b want 0", dmem_rd); end
        n_chk++; if ({wb_valid, wb_err, wb_reg_write} !== 3'b110) begin n_fail++; $display("FAIL misal_wb got %b want 110", {wb_valid, wb_err, wb_reg_write}); end
        n_chk++; if (wb_data !== 16'h0) begin n_fail++; $display("FAIL misal_data got %h want 0000", wb_data); end
        n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL misal_ready got %b want 1", ex_ready); end
        ex_valid = 1; ex_mem_read = 1; ex_mem_write = 1; ex_alu_result = 16'h0044; ex_reg_write = 1;
        tick(); clr_ex();
        n_chk++; if ({dmem_rd, dmem_wr} !== 2'b00) begin n_fail++; $display("FAIL both_no_req got %b want 00", {dmem_rd, dmem_wr}); end
        n_chk++; if ({wb_valid, wb_err, wb_reg_write} !== 3'b110) begin n_fail++; $display("FAIL both_wb got %b want 110", {wb_valid, wb_err, wb_reg_write}); end
        dmem_done = 1; dmem_rdata = 16'hDEAD;
        tick(); dmem_done = 0; dmem_rdata = 0;
        n_chk++; if ({wb_valid, ex_ready} !== 2'b01) begin n_fail++; $display("FAIL idle_done got %b want 01", {wb_valid, ex_ready}); end
    endtask

    task automatic test_timeout();
        ex_valid = 1; ex_mem_read = 1; ex_alu_result = 16'h0020; ex_reg_write = 1; ex_wr_reg = 6;
        tick(); clr_ex();
        for (int i = 0; i < 4; i++) begin
            n_chk++; if ({dmem_rd, ex_ready, wb_valid} !== 3'b100) begin n_fail++; $display("FAIL to_wait[%0d] got %b want 100", i, {dmem_rd, ex_ready, wb_valid}); end
            tick();
        end
        n_chk++; if (dmem_rd !== 1'b0) begin n_fail++; $display("FAIL to_drop got %b want 0", dmem_rd); end
        n_chk++; if ({wb_valid, wb_err, wb_reg_write} !== 3'b110) begin n_fail++; $display("FAIL to_wb got %b want 110", {wb_valid, wb_err, wb_reg_write}); end
        n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL to_ready got %b want 1", ex_ready); end
        ex_valid = 1; ex_mem_read = 1; ex_alu_result = 16'h0022; ex_reg_write = 1; ex_wr_reg = 1;
        tick(); clr_ex();
        tick(); tick(); tick();
        dmem_done = 1; dmem_rdata = 16'hA5A5;
        tick(); dmem_done = 0; dmem_rdata = 0;
        n_chk++; if ({wb_valid, wb_err, wb_reg_write} !== 3'b101) begin n_fail++; $display("FAIL to_done_wins got %b want 101", {wb_valid, wb_err, wb_reg_write}); end
        n_chk++; if (wb_data !== 16'hA5A5) begin n_fail++; $display("FAIL to_done_data got %h want a5a5", wb_data); end
    endtask

    task automatic test_rst_busy_halt();
        ex_valid = 1; ex_mem_read = 1; ex_alu_result = 16'h0050; ex_reg_write = 1;
        tick(); clr_ex();
        n_chk++; if (dmem_rd !== 1'b1) begin n_fail++; $display("FAIL rb_rd1 got %b want 1", dmem_rd); end
        tick();
        rst = 1;
        tick(); rst = 0;
        n_chk++; if ({dmem_rd, wb_valid, ex_ready} !== 3'b001) begin n_fail++; $display("FAIL rb_after got %b want 001", {dmem_rd, wb_valid, ex_ready}); end
        dmem_done = 1;
        tick(); dmem_done = 0;
        n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rb_no_pulse got %b want 0", wb_valid); end
        ex_valid = 1; ex_halt = 1;
        tick(); clr_ex();
        n_chk++; if ({wb_valid, wb_halt, dmem_createdump} !== 3'b111) begin n_fail++; $display("FAIL halt_pulse got %b want 111", {wb_valid, wb_halt, dmem_createdump}); end
        n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL halt_ready got %b want 1", ex_ready); end
        tick();
        n_chk++; if ({wb_valid, wb_halt, dmem_createdump} !== 3'b000) begin n_fail++; $display("FAIL halt_one_cycle got %b want 000", {wb_valid, wb_halt, dmem_createdump}); end
    endtask

    task automatic test_back_to_back();
        ex_valid = 1; ex_alu_result = 16'h1111; ex_reg_write = 1; ex_wr_reg = 1;
        tick();
        ex_alu_result = 16'h2222; ex_wr_reg = 2;
        n_chk++; if ({wb_valid, wb_data, wb_wr_reg} !== {1'b1, 16'h1111, 3'd1}) begin n_fail++; $display("FAIL b2b_first got %b_%h_%0d want 1_1111_1", wb_valid, wb_data, wb_wr_reg); end
        tick(); clr_ex();
        n_chk++; if ({wb_valid, wb_data, wb_wr_reg} !== {1'b1, 16'h2222, 3'd2}) begin n_fail++; $display("FAIL b2b_second got %b_%h_%0d want 1_2222_2", wb_valid, wb_data, wb_wr_reg); end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load();
        test_store();
        test_errors();
        test_timeout();
        test_rst_busy_halt();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
